// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Cyclic priority encoder: first requesting line at or after ptr, optionally
// skipping one excluded line.
module rr_prio_enc
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               excl_en,
    input  logic [IDX_W-1:0]   excl_idx,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Index arithmetic wraps naturally at IDX_W bits (3 -> 0).
            cand = ptr + IDX_W'(k);
            if (!win_valid && req[cand] && !(excl_en && (cand == excl_idx))) begin
                win_idx   = cand;
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Locking round-robin arbiter for 4 requesters with registered one-hot grant.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles under contention.
//
//   state | meaning
//   IDLE  | no grant outstanding, arbitrate from ptr
//   GRANT | gnt_idx owns the resource until it drops req (or times out)
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] enc_ptr;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             owner_req;
    logic             timeout;
    logic             handover;

    assign owner_req = req[gnt_idx];
    assign next_ptr  = gnt_idx + IDX_W'(1);

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic              others_pending;
    logic              hold_last;

    assign others_pending = |(req & ~gnt);
    assign hold_last      = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign timeout        = hold_last && owner_req && others_pending;
`else
    logic [HOLD_W-1:0] unused_max_hold;

    assign unused_max_hold = HOLD_W'(MAX_HOLD);
    assign timeout         = 1'b0;
`endif

    assign handover = !owner_req || timeout;

    // In GRANT the encoder already looks from owner+1 and skips the owner, so
    // release and forced rotation share one arbitration path.
    assign enc_ptr = (state == GRANT) ? next_ptr : ptr;

    rr_prio_enc u_prio_enc (
        .req       (req),
        .ptr       (enc_ptr),
        .excl_en   (state == GRANT),
        .excl_idx  (gnt_idx),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state     <= GRANT;
                        gnt       <= onehot(win_idx);
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (handover) begin
                        ptr <= next_ptr;
                        if (win_valid) begin
                            gnt       <= onehot(win_idx);
                            gnt_idx   <= win_idx;
                            gnt_valid <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_idx   <= '0;
                            gnt_valid <= 1'b0;
                        end
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        // Uncontended owner: restart the window rather than wrap.
                        hold_cnt <= hold_last ? '0 : hold_cnt + HOLD_W'(1);
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_idx   <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
